core_prefetch: RTL and testbench

//  Instruction prefetch queue between the core's decode stage and core_mmu's insn port.

---
 rtl/core_prefetch.sv | 124 ++++++++++++
 tb/tb_core_prefetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_prefetch.sv
// Instruction prefetch queue: keeps one sequential word fetch outstanding at the MMU
// and buffers returned words with their PC for decode. Flush discards queue and in-flight data.
module core_prefetch #(
    parameter int ORDER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [29:0] target,
    input  logic        fetch,
    output logic        fetched,
    output logic [31:0] insn,
    output logic [29:0] insn_pc,
    output logic        insn_start,
    output logic [29:0] insn_addr,
    input  logic        insn_ready,
    input  logic [31:0] insn_data_rd
);

    localparam int DEPTH = 2 ** ORDER;
    localparam int PW    = ORDER + 1;
    localparam int CW    = ORDER + 2;

    logic [PW-1:0]    count_q, count_d;
    logic [ORDER-1:0] rd_ptr_q, rd_ptr_d;
    logic [ORDER-1:0] wr_ptr_q, wr_ptr_d;
    logic [29:0]      next_pc_q, next_pc_d;
    logic [29:0]      req_pc_q, req_pc_d;
    logic             busy_q, busy_d;
    logic             discard_q, discard_d;

    logic [31:0]      word_mem_q [DEPTH];
    logic [29:0]      pc_mem_q   [DEPTH];

    logic             pop;
    logic             resp;
    logic             wr;
    logic             room;
    logic             issue;
    logic [CW-1:0]    occupancy;

    // An outstanding request already owns a slot, so a response never overflows the FIFO.
    assign fetched   = (count_q != '0);
    assign pop       = fetch && fetched;
    assign resp      = insn_ready && busy_q;
    assign wr        = resp && !discard_q && !flush;
    assign occupancy = CW'(count_q) + CW'(busy_q) - CW'(pop);
    assign room      = (occupancy < CW'(DEPTH));
    assign issue     = !rst && !flush && room && (!busy_q || insn_ready);

    assign insn_start = issue;
    assign insn_addr  = next_pc_q;
    assign insn       = word_mem_q[rd_ptr_q];
    assign insn_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        next_pc_d = next_pc_q;
        req_pc_d  = req_pc_q;
        busy_d    = busy_q;
        discard_d = discard_q;

        if (flush) begin
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            next_pc_d = target;
            // A request still in flight must be absorbed before the target is fetched.
            if (busy_q && !insn_ready) begin
                busy_d    = 1'b1;
                discard_d = 1'b1;
            end else begin
                busy_d    = 1'b0;
                discard_d = 1'b0;
            end
        end else begin
            if (issue) begin
                next_pc_d = next_pc_q + 30'd1;
                req_pc_d  = next_pc_q;
            end
            busy_d = issue || (busy_q && !insn_ready);
            if (resp) begin
                discard_d = 1'b0;
            end
            if (wr) begin
                wr_ptr_d = wr_ptr_q + ORDER'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ORDER'(1);
            end
            count_d = count_q + PW'(wr) - PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            next_pc_q <= '0;
            req_pc_q  <= '0;
            busy_q    <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            next_pc_q <= next_pc_d;
            req_pc_q  <= req_pc_d;
            busy_q    <= busy_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            word_mem_q[wr_ptr_q] <= insn_data_rd;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_core_prefetch.sv
// Bench for core_prefetch: behavioural MMU with configurable latency, address-sequence
// model and a pc/word scoreboard fed from each restart point.
module tb_core_prefetch;
    // valid/ready: insn_start is a one-cycle request; the MMU answers with exactly one
    // insn_ready pulse later; decode consumes the head when fetch && fetched at posedge.

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [29:0] target;
    logic        fetch;
    logic        fetched;
    logic [31:0] insn;
    logic [29:0] insn_pc;
    logic        insn_start;
    logic [29:0] insn_addr;
    logic        insn_ready;
    logic [31:0] insn_data_rd;

    int errors = 0;
    int checks = 0;
    int n_pops = 0;
    int cyc    = 0;
    int mmu_lat = 2;

    logic [61:0] exp_q[$];
    int          mq_due[$];
    logic [29:0] mq_addr[$];

    core_prefetch #(.ORDER(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .target       (target),
        .fetch        (fetch),
        .fetched      (fetched),
        .insn         (insn),
        .insn_pc      (insn_pc),
        .insn_start   (insn_start),
        .insn_addr    (insn_addr),
        .insn_ready   (insn_ready),
        .insn_data_rd (insn_data_rd)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        target = '0;
        fetch  = 1'b0;
    end

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decode must see target, target+1, ... with memory contents for each address.
    task automatic push_window(input logic [29:0] start);
        logic [29:0] a;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = start + 30'(i);
            exp_q.push_back({word_of(a), a});
        end
    endtask

    // driver tasks: inputs change on negedge, outputs read 1 time unit later
    task automatic tick(input logic fe);
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        fetch = fe;
        #1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst   = 1'b1;
            flush = 1'b0;
            fetch = 1'b0;
            push_window(30'd0);
            #1;
        end
    endtask

    task automatic do_flush(input logic [29:0] t, input logic fe);
        @(negedge clk);
        rst    = 1'b0;
        flush  = 1'b1;
        target = t;
        fetch  = fe;
        push_window(t);
        #1;
    endtask

    // behavioural MMU: answers each request after its latency, independent of flush/rst
    initial begin
        int lat;
        insn_ready   = 1'b0;
        insn_data_rd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                insn_ready   = 1'b1;
                insn_data_rd = word_of(mq_addr[0]);
                void'(mq_due.pop_front());
                void'(mq_addr.pop_front());
            end else begin
                insn_ready   = 1'b0;
                insn_data_rd = $urandom;
            end
            #3;
            if (insn_start) begin
                lat = (mmu_lat == 0) ? int'($urandom_range(1, 4)) : mmu_lat;
                mq_due.push_back(cyc + lat);
                mq_addr.push_back(insn_addr);
            end
        end
    end

    // monitor / scoreboard
    initial begin
        logic [29:0] exp_req;
        logic        prev_clear;
        exp_req    = '0;
        prev_clear = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (prev_clear && !rst && !flush) begin
                check("fetched_after_clear", fetched, 0);
            end
            if (rst) begin
                check("start_in_reset", insn_start, 0);
                exp_req    = '0;
                prev_clear = 1'b1;
            end else if (flush) begin
                check("start_in_flush", insn_start, 0);
                exp_req    = target;
                prev_clear = 1'b1;
            end else begin
                prev_clear = 1'b0;
                if (insn_start) begin
                    check("req_addr", insn_addr, exp_req);
                    exp_req = exp_req + 30'd1;
                end
                if (fetch && fetched) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", 1, 0);
                    end else begin
                        check("fifo_head", {insn, insn_pc}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // stimulus
    initial begin
        int starts;
        int p0;
        int since_flush;
        int r;
        logic found;
        logic [29:0] t;

        // sequential fetch after reset, 2-cycle MMU
        mmu_lat = 2;
        do_reset(3);
        p0 = n_pops;
        repeat (40) tick(1'b1);
        check("t1_words_delivered", (n_pops - p0 >= 15), 1);

        // full queue with no decode: exactly DEPTH requests
        do_reset(3);
        starts = 0;
        repeat (30) begin
            tick(1'b0);
            if (insn_start) starts++;
        end
        check("t2_starts_full", starts, 4);
        check("t2_fetched", fetched, 1);

        // one pop refills exactly one slot
        tick(1'b1);
        starts = insn_start ? 1 : 0;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0);
            if (insn_ready) begin
                found = 1'b1;
                // pop and write together at count = DEPTH-1
                fetch = 1'b1;
                #1;
                check("t5_issue_on_pop_write", insn_start, 1);
            end else if (insn_start) begin
                starts++;
            end
        end
        check("t5_ready_seen", found, 1);
        check("t2_one_refill", starts, 1);
        starts = 0;
        repeat (20) begin
            tick(1'b0);
            if (insn_start) starts++;
        end
        check("t5_no_overflow_issue", starts, 0);
        check("t5_still_full", fetched, 1);

        // zero-wait MMU: one word per cycle
        mmu_lat = 1;
        repeat (10) tick(1'b1);
        starts = 0;
        repeat (30) begin
            tick(1'b1);
            if (insn_start) starts++;
        end
        check("t3_one_per_cycle", starts, 30);

        // flush while the request to 0x5 is outstanding
        mmu_lat = 4;
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b1);
            if (insn_start && insn_addr == 30'h5) found = 1'b1;
        end
        check("t4_reach_5", found, 1);
        do_flush(30'h100, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b1);
            if (insn_start) begin
                found = 1'b1;
                check("t4_first_addr", insn_addr, 30'h100);
                check("t4_issue_with_stale_ready", insn_ready, 1);
            end
        end
        check("t4_restart_seen", found, 1);
        repeat (20) tick(1'b1);

        // address wrap
        mmu_lat = 1;
        do_flush(30'h3FFF_FFFE, 1'b0);
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1'b1);
            if (insn_start) begin
                starts++;
                if (starts == 3) check("t6_wrap_addr", insn_addr, 30'h0);
            end
        end

        // reset mid-request: stale response lands the cycle after reset
        mmu_lat = 3;
        do_reset(2);
        tick(1'b0);
        check("t6_first_start", insn_start, 1);
        do_reset(2);
        tick(1'b0);
        check("t6_stale_ready_present", insn_ready, 1);
        check("t6_start_after_reset", insn_start, 1);
        tick(1'b0);
        check("t6_stale_ignored", fetched, 0);
        repeat (15) tick(1'b1);

        // randomized traffic with random flushes and MMU latency
        mmu_lat = 0;
        do_reset(3);
        since_flush = 0;
        repeat (2500) begin
            since_flush++;
            r = int'($urandom_range(0, 99));
            if (r < 3 || since_flush > 180) begin
                t = ($urandom_range(0, 1) == 1) ? (30'h3FFF_FFF0 + 30'($urandom_range(0, 15)))
                                                : 30'($urandom);
                do_flush(t, 1'($urandom_range(0, 1)));
                since_flush = 0;
            end else begin
                tick($urandom_range(0, 3) != 0);
            end
        end
        repeat (10) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
